cntry_car_detector: RTL and testbench



---
 rtl/traffic_pkg.sv | 20 ++
 rtl/cntry_car_detector_loop_debounce.sv | 59 +++++
 rtl/cntry_car_detector.sv | 151 +++++++++++++++
 tb/tb_cntry_car_detector.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the country-road traffic controller: the 2-bit
// signal colours (also used by sig_control), the car-detector FSM states
// and boolean constants.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUEUED  = 2'd1,
    SERVING = 2'd2,
    HOLDOFF = 2'd3
  } det_state_t;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/cntry_car_detector_loop_debounce.sv
// loop_debounce: two-flop synchroniser on the raw loop sensor, a debouncer
// that only moves its level after DEBOUNCE consecutive disagreeing samples,
// and a one-cycle pulse on the debounced rising edge.
module loop_debounce
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic i_clk,
  input  logic i_clear,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_run;

  // Bring the asynchronous loop input into the clk domain.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_sync1 <= FALSE;
      r_sync2 <= FALSE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count disagreeing samples; a matching sample restarts the run. The rise
  // pulse is registered together with the level change so it lasts one cycle.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_run   <= '0;
      r_level <= FALSE;
      r_rise  <= FALSE;
    end else begin
      r_rise <= FALSE;
      if (r_sync2 == r_level) begin
        r_run <= '0;
      end else if (r_run == CW'(DEBOUNCE - 1)) begin
        r_run   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_run <= r_run + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/cntry_car_detector.sv
// cntry_car_detector: turns the debounced loop into a queued-vehicle count
// and a registered CAR_ON_CNTRY_RD request, serving one vehicle every
// SERVE_CYCLES of country GREEN and dropping the request after MAX_HOLD
// GREEN cycles so the main road cannot starve.
// Optional stuck-sensor detection/recall mode: define CNTRY_STUCK_DET_EN.
module cntry_car_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE     = 3,
  parameter int SERVE_CYCLES = 4,
  parameter int MAX_HOLD     = 40,
  parameter int QW           = 4,
  parameter int STUCK_LIMIT  = 64
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          loop_raw,
  input  logic [1:0]    CNTRY_SIG,
  output logic          CAR_ON_CNTRY_RD,
  output logic [QW-1:0] car_count,
  output logic          sensor_fault
);

  localparam int SW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [QW-1:0] CNT_MAX = {QW{1'b1}};

  det_state_t    r_state;
  det_state_t    w_next;
  logic [QW-1:0] r_count;
  logic [QW-1:0] w_count_next;
  logic [SW-1:0] r_svc;
  logic [HW-1:0] r_hold;
  logic          r_req;
  logic          w_level;
  logic          w_rise;
  logic          w_fault;
  logic          w_arrival;
  logic          w_tick;
  logic          w_green;
  logic          w_has_cars;
  logic          w_empty_next;

  loop_debounce #(.DEBOUNCE(DEBOUNCE)) u_loop_debounce (
    .i_clk   (clk),
    .i_clear (clear),
    .i_raw   (loop_raw),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

`ifdef CNTRY_STUCK_DET_EN
  localparam int KW = $clog2(STUCK_LIMIT + 1);
  logic [KW-1:0] r_stuck_cnt;
  logic          r_fault;

  // Count consecutive debounced-high cycles; the fault is sticky until clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_stuck_cnt <= '0;
      r_fault     <= FALSE;
    end else begin
      if (!w_level) begin
        r_stuck_cnt <= '0;
      end else if (r_stuck_cnt != KW'(STUCK_LIMIT)) begin
        r_stuck_cnt <= r_stuck_cnt + 1'b1;
      end
      if (w_level && (r_stuck_cnt == KW'(STUCK_LIMIT - 1))) begin
        r_fault <= TRUE;
      end
    end
  end

  assign w_fault = r_fault;
`else
  localparam int unused_stuck_limit = STUCK_LIMIT;
  logic w_unused_level;
  assign w_unused_level = w_level;
  assign w_fault        = FALSE;
`endif

  assign w_green   = (CNTRY_SIG == GREEN);
  assign w_arrival = w_rise && !w_fault;
  assign w_tick    = (r_state == SERVING) && w_green && (r_svc == SW'(SERVE_CYCLES - 1));

  // Queue arithmetic: saturating increment, floor at 0 (at 1 in recall mode),
  // and a simultaneous arrival and tick cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_arrival && !w_tick) begin
      if (r_count != CNT_MAX) w_count_next = r_count + 1'b1;
    end else if (w_tick && !w_arrival) begin
      if ((r_count != '0) && !(w_fault && (r_count == QW'(1)))) begin
        w_count_next = r_count - 1'b1;
      end
    end
  end

  // In recall mode the queue always looks non-empty to the FSM.
  assign w_has_cars   = w_fault || (r_count != '0);
  assign w_empty_next = !w_fault && (w_count_next == '0);

  // Next-state logic; SERVING exits in priority: empty, max hold, lost GREEN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_has_cars) w_next = QUEUED;
      QUEUED:  if (w_green) w_next = SERVING;
      SERVING: begin
        if (w_empty_next)                      w_next = IDLE;
        else if (r_hold == HW'(MAX_HOLD - 1))  w_next = HOLDOFF;
        else if (!w_green)                     w_next = QUEUED;
      end
      HOLDOFF: if (CNTRY_SIG == RED) w_next = w_has_cars ? QUEUED : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, queue and request registers; the request lags the state by a cycle.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_count <= '0;
      r_req   <= FALSE;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      r_req   <= (r_state == QUEUED) || (r_state == SERVING);
    end
  end

  // Service and hold timers: cleared on entry to SERVING, advanced only there;
  // the service timer pauses while the country signal is not GREEN.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_svc  <= '0;
      r_hold <= '0;
    end else if ((r_state == QUEUED) && (w_next == SERVING)) begin
      r_svc  <= '0;
      r_hold <= '0;
    end else if (r_state == SERVING) begin
      r_hold <= r_hold + 1'b1;
      if (w_green) r_svc <= w_tick ? '0 : r_svc + 1'b1;
    end
  end

  assign CAR_ON_CNTRY_RD = r_req;
  assign car_count       = r_count;
  assign sensor_fault    = w_fault;

endmodule

// File: tb/tb_cntry_car_detector.sv
// Directed bench for cntry_car_detector at default parameters. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_cntry_car_detector;
  import traffic_pkg::*;

  logic       clk;
  logic       clear;
  logic       loop_raw;
  logic [1:0] cntry_sig;
  logic       car_on;
  logic [3:0] car_count;
  logic       sensor_fault;

  int n_checks;
  int n_pass;

`ifdef CNTRY_STUCK_DET_EN
  localparam logic EXP_FAULT = 1'b1;
`else
  localparam logic EXP_FAULT = 1'b0;
`endif

  cntry_car_detector dut (
    .clk             (clk),
    .clear           (clear),
    .loop_raw        (loop_raw),
    .CNTRY_SIG       (cntry_sig),
    .CAR_ON_CNTRY_RD (car_on),
    .car_count       (car_count),
    .sensor_fault    (sensor_fault)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 time unit
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one vehicle: loop high 5 cycles, low 5 cycles (debounced up and down)
  task automatic car();
    loop_raw = 1'b1;
    step(5);
    loop_raw = 1'b0;
    step(5);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    clear     = 1'b1;
    loop_raw  = 1'b0;
    cntry_sig = RED;
    step(2);
    check("rst_req", car_on, 0);
    check("rst_count", car_count, 0);
    check("rst_fault", sensor_fault, 0);
    check("rst_state", int'(dut.r_state), int'(IDLE));

    // 1: single car, request after edge 7, served in 4 GREEN cycles
    clear    = 1'b0;
    loop_raw = 1'b1;
    step(7);
    check("t1_req_edge6", car_on, 0);
    check("t1_count_edge6", car_count, 1);
    step(1);
    check("t1_req_edge7", car_on, 1);
    step(2);
    loop_raw  = 1'b0;
    cntry_sig = GREEN;
    step(4);
    check("t1_count_g3", car_count, 1);
    step(1);
    check("t1_count_g4", car_count, 0);
    check("t1_req_g4", car_on, 1);
    step(1);
    check("t1_req_fall", car_on, 0);
    check("t1_state_idle", int'(dut.r_state), int'(IDLE));
    cntry_sig = RED;
    step(6);

    // 2: 2-cycle glitch is rejected
    loop_raw = 1'b1;
    step(2);
    loop_raw = 1'b0;
    step(10);
    check("t2_count", car_count, 0);
    check("t2_req", car_on, 0);

    // 3: three cars served 3,2,1,0 every 4 GREEN cycles
    for (int i = 0; i < 3; i++) car();
    check("t3_count_q", car_count, 3);
    check("t3_req_q", car_on, 1);
    cntry_sig = GREEN;
    step(1);
    for (int i = 0; i < 3; i++) begin
      step(4);
      check($sformatf("t3_count_tick%0d", i), car_count, 2 - i);
    end
    check("t3_req_g12", car_on, 1);
    step(1);
    check("t3_req_fall", car_on, 0);
    cntry_sig = RED;
    step(2);

    // 5a: arrival coincides with a service tick -> count unchanged
    car();
    car();
    check("t5_count_q", car_count, 2);
    loop_raw = 1'b1;
    step(1);
    cntry_sig = GREEN;
    step(4);
    check("t5_count_pre", car_count, 2);
    step(1);
    check("t5_count_same", car_count, 2);
    loop_raw = 1'b0;
    step(4);
    check("t5_count_tick2", car_count, 1);
    step(4);
    check("t5_count_empty", car_count, 0);
    step(1);
    check("t5_req_fall", car_on, 0);
    cntry_sig = RED;
    step(2);

    // 5b + 4: 16 arrivals saturate at 15, then max hold under GREEN
    for (int i = 0; i < 16; i++) car();
    check("t4_count_sat", car_count, 15);
    check("t4_req_q", car_on, 1);
    cntry_sig = GREEN;
    step(1);
    step(39);
    check("t4_count_g39", car_count, 6);
    check("t4_req_g39", car_on, 1);
    step(1);
    check("t4_count_g40", car_count, 5);
    check("t4_state_hold", int'(dut.r_state), int'(HOLDOFF));
    step(1);
    check("t4_req_hold", car_on, 0);
    cntry_sig = YELLOW;
    step(3);
    check("t4_req_yellow", car_on, 0);
    cntry_sig = RED;
    step(1);
    check("t4_req_red1", car_on, 0);
    step(1);
    check("t4_req_red2", car_on, 1);
    check("t4_count_red", car_count, 5);

    // 6: clear while SERVING with count 3
    cntry_sig = GREEN;
    step(1);
    step(8);
    check("t6_count_pre", car_count, 3);
    check("t6_state_pre", int'(dut.r_state), int'(SERVING));
    clear = 1'b1;
    step(1);
    clear     = 1'b0;
    cntry_sig = RED;
    check("t6_count_clr", car_count, 0);
    check("t6_req_clr", car_on, 0);
    check("t6_state_clr", int'(dut.r_state), int'(IDLE));

    // loop held high: one arrival; stuck flag only with the detector built
    loop_raw = 1'b1;
    step(80);
    check("stk_count", car_count, 1);
    check("stk_req", car_on, 1);
    check("stk_fault", sensor_fault, int'(EXP_FAULT));
`ifdef CNTRY_STUCK_DET_EN
    cntry_sig = GREEN;
    step(41);
    check("stk_count_floor", car_count, 1);
    step(1);
    check("stk_req_hold", car_on, 0);
    cntry_sig = RED;
    step(2);
    check("stk_req_recall", car_on, 1);
`endif
    loop_raw = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
